// File: rtl/filter_stream_ctrl.sv
// Raster-scan initiator for a pixel filter with a credit-checked output FIFO.
// Ports: CLK/RST, START/BUSY/DONE/OVERFLOW control, SRC_* source buffer,
//   POSX/POSY/READY/IN_* and FILT_RDEN/FILT_WREN/FILT_* filter side,
//   DST_VALID/DST_RGB/DST_READY frame-writer side.
module filter_stream_ctrl #(
    parameter int WIDTH     = 1600,
    parameter int HEIGHT    = 900,
    parameter int OUT_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERFLOW,
    input  logic        SRC_VALID,
    input  logic [23:0] SRC_RGB,
    output logic        SRC_POP,
    output logic [11:0] POSX,
    output logic [11:0] POSY,
    output logic        READY,
    input  logic        FILT_RDEN,
    output logic [7:0]  IN_R,
    output logic [7:0]  IN_G,
    output logic [7:0]  IN_B,
    input  logic        FILT_WREN,
    input  logic [7:0]  FILT_R,
    input  logic [7:0]  FILT_G,
    input  logic [7:0]  FILT_B,
    output logic        DST_VALID,
    output logic [23:0] DST_RGB,
    input  logic        DST_READY
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [11:0]     posx_q, posx_d;
    logic [11:0]     posy_q, posy_d;
    logic [CW-1:0]   infl_q, infl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [23:0]     mem_q [OUT_DEPTH];
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic            ready, push, pop, full, last_px;
    logic [CW:0]     credit;

    // RDEN is a mirror of READY from the filter; nothing to act on here.
    logic            unused_rden;
    assign unused_rden = FILT_RDEN;

    // Credits cover both pixels in the filter and pixels already queued,
    // so a returning WREN always finds a free slot.
    assign credit  = {1'b0, infl_q} + {1'b0, cnt_q};
    assign ready   = (state_q == S_RUN) && SRC_VALID
                   && (credit < (CW+1)'(OUT_DEPTH));
    assign full    = (cnt_q == CW'(OUT_DEPTH));
    assign pop     = (cnt_q != '0) && DST_READY;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = FILT_WREN && (!full || pop);
    assign last_px = (posx_q == 12'(WIDTH - 1))
                   && (posy_q == 12'(HEIGHT - 1));

    always_comb begin
        state_d = state_q;
        posx_d  = posx_q;
        posy_d  = posy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_RUN;
                    posx_d  = '0;
                    posy_d  = '0;
                end
            end
            S_RUN: begin
                if (ready) begin
                    if (last_px) begin
                        state_d = S_DRAIN;
                    end else if (posx_q == 12'(WIDTH - 1)) begin
                        posx_d = '0;
                        posy_d = posy_q + 12'd1;
                    end else begin
                        posx_d = posx_q + 12'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (infl_q == '0 && cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        infl_d = infl_q;
        if (ready && !FILT_WREN) begin
            infl_d = infl_q + CW'(1);
        end else if (!ready && FILT_WREN && infl_q != '0) begin
            // Late strobes after a reset must not wrap the counter.
            infl_d = infl_q - CW'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q | (FILT_WREN && full && !pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            posx_q  <= '0;
            posy_q  <= '0;
            infl_q  <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            infl_q  <= infl_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= {FILT_R, FILT_G, FILT_B};
    end

    assign READY     = ready;
    assign SRC_POP   = ready;
    assign POSX      = posx_q;
    assign POSY      = posy_q;
    assign IN_R      = SRC_RGB[23:16];
    assign IN_G      = SRC_RGB[15:8];
    assign IN_B      = SRC_RGB[7:0];
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign OVERFLOW  = ovf_q;
    assign DST_VALID = (cnt_q != '0);
    assign DST_RGB   = mem_q[rptr_q];

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Randomized bench for filter_stream_ctrl with a 2-cycle echo filter
// and a queue-based reference model of the frame and output FIFO.
module tb_filter_stream_ctrl;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int D   = 4;
    localparam int NPX = W * H;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        BUSY, DONE, OVERFLOW;
    logic        SRC_VALID = 1'b0;
    logic [23:0] SRC_RGB = '0;
    logic        SRC_POP;
    logic [11:0] POSX, POSY;
    logic        READY;
    logic        FILT_RDEN;
    logic [7:0]  IN_R, IN_G, IN_B;
    logic        FILT_WREN;
    logic [7:0]  FILT_R, FILT_G, FILT_B;
    logic        DST_VALID;
    logic [23:0] DST_RGB;
    logic        DST_READY = 1'b0;

    filter_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .OUT_DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW),
        .SRC_VALID(SRC_VALID), .SRC_RGB(SRC_RGB), .SRC_POP(SRC_POP),
        .POSX(POSX), .POSY(POSY), .READY(READY),
        .FILT_RDEN(FILT_RDEN),
        .IN_R(IN_R), .IN_G(IN_G), .IN_B(IN_B),
        .FILT_WREN(FILT_WREN),
        .FILT_R(FILT_R), .FILT_G(FILT_G), .FILT_B(FILT_B),
        .DST_VALID(DST_VALID), .DST_RGB(DST_RGB), .DST_READY(DST_READY)
    );

    always #5 CLK = ~CLK;

    // Echo filter: output appears two edges after the pixel is taken.
    logic        v1, pv;
    logic [23:0] d1, pd;
    logic        force_w = 1'b0;
    logic [23:0] force_rgb = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1 <= 1'b0; pv <= 1'b0; d1 <= '0; pd <= '0;
        end else begin
            v1 <= READY;
            d1 <= {IN_R ^ 8'h5a, IN_G + 8'd1, ~IN_B};
            pv <= v1;
            pd <= d1;
        end
    end

    assign FILT_RDEN = READY;
    assign FILT_WREN = pv | force_w;
    assign {FILT_R, FILT_G, FILT_B} = force_w ? force_rgb : pd;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    int          issued, m_infl, ndone, nready;
    bit          m_run, m_busy, m_ovf, exp_done;
    logic [23:0] q[$];
    logic [23:0] src[NPX];
    int          sv_mode, dr_mode;
    bit          tog, start_req, force_req;
    logic [23:0] force_data;

    task automatic model_reset();
        issued = NPX; m_infl = 0; m_run = 0; m_busy = 0;
        m_ovf = 0; exp_done = 0; q.delete();
    endtask

    task automatic tick();
        bit busy_now, exp_rdy, pop;
        @(negedge CLK);
        tog = ~tog;
        SRC_VALID = (sv_mode == 0) ? 1'b1 : (sv_mode == 1) ? tog
                  : 1'($urandom_range(0, 1));
        DST_READY = (dr_mode == 0) ? 1'b1 : (dr_mode == 1) ? 1'b0
                  : 1'($urandom_range(0, 1));
        SRC_RGB = (issued < NPX) ? src[issued] : 24'($urandom);
        START = start_req;
        start_req = 0;
        force_w = force_req;
        force_rgb = force_data;
        #1;
        exp_rdy = m_run && SRC_VALID && (m_infl + q.size() < D);
        check("ready", READY, exp_rdy);
        check("busy", BUSY, m_busy);
        check("done", DONE, exp_done);
        check("dst_valid", DST_VALID, q.size() != 0);
        check("overflow", OVERFLOW, m_ovf);
        if (DONE) ndone++;
        if (READY) begin
            nready++;
            check("posx", POSX, issued % W);
            check("posy", POSY, issued / W);
            check("in_rgb", {IN_R, IN_G, IN_B},
                  (issued < NPX) ? src[issued] : 24'h0);
            check("src_pop", SRC_POP, 1);
        end
        if (DST_VALID && q.size() != 0) check("dst_rgb", DST_RGB, q[0]);
        // Advance model across the coming edge
        busy_now = m_busy;
        exp_done = m_busy && !m_run && m_infl == 0 && q.size() == 0;
        if (exp_done) m_busy = 0;
        pop = (q.size() != 0) && DST_READY;
        if (exp_rdy && !FILT_WREN) m_infl++;
        else if (!exp_rdy && FILT_WREN && m_infl > 0) m_infl--;
        if (pop) void'(q.pop_front());
        if (FILT_WREN) begin
            if (q.size() < D) q.push_back({FILT_R, FILT_G, FILT_B});
            else m_ovf = 1;
        end
        if (exp_rdy) begin
            issued++;
            if (issued == NPX) m_run = 0;
        end
        if (START && !busy_now) begin
            m_busy = 1; m_run = 1; issued = 0;
            for (int i = 0; i < NPX; i++) src[i] = 24'($urandom);
        end
    endtask

    task automatic begin_frame();
        ndone = 0; nready = 0; start_req = 1;
    endtask

    task automatic wait_done(string tag, int budget);
        int n = 0;
        while (ndone == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({tag, "_done_once"}, ndone, 1);
        check({tag, "_issued"}, nready, NPX);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        tog = 0; start_req = 0; force_req = 0; force_data = '0;
        sv_mode = 0; dr_mode = 0; ndone = 0; nready = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check("rst_posx", POSX, 0);
        check("rst_posy", POSY, 0);
        check("rst_ready", READY, 0);
        check("rst_srcpop", SRC_POP, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_dstv", DST_VALID, 0);
        check("rst_ovf", OVERFLOW, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Continuous flow
        sv_mode = 0; dr_mode = 0;
        begin_frame();
        wait_done("t1", 100);

        // Source stalls every other cycle
        sv_mode = 1; dr_mode = 0;
        begin_frame();
        wait_done("t2", 150);

        // Writer stalled: credits stop issue at FIFO depth
        sv_mode = 0; dr_mode = 1;
        begin_frame();
        repeat (20) tick();
        check("t3_stalled_issue", nready, D);
        check("t3_fifo_valid", DST_VALID, 1);
        check("t3_no_ovf", OVERFLOW, 0);
        dr_mode = 0;
        wait_done("t3", 150);

        // Second START mid-frame, random handshakes
        sv_mode = 2; dr_mode = 2;
        begin_frame();
        repeat (5) tick();
        start_req = 1;
        wait_done("t4", 400);

        // Async reset mid-frame at (2,1)
        sv_mode = 0; dr_mode = 0;
        begin_frame();
        for (int n = 0; n < 50 && issued != W + 2; n++) tick();
        @(negedge CLK);
        check("t5_pre_posx", POSX, 2);
        check("t5_pre_posy", POSY, 1);
        RST = 1'b1;
        #1;
        check("t5_posx", POSX, 0);
        check("t5_posy", POSY, 0);
        check("t5_busy", BUSY, 0);
        check("t5_dstv", DST_VALID, 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        begin_frame();
        wait_done("t5", 100);

        // Forced strobes in IDLE: fill, push+pop at full, then overflow
        dr_mode = 1;
        for (int i = 0; i < D; i++) begin
            force_req = 1; force_data = 24'($urandom);
            tick();
        end
        dr_mode = 0;
        force_data = 24'($urandom);
        tick();
        dr_mode = 1;
        force_data = 24'($urandom);
        tick();
        force_req = 0;
        tick();
        check("t6_ovf_set", OVERFLOW, 1);
        dr_mode = 0;
        nready = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (DST_VALID) nready++;
        end
        check("t6_drain_count", nready, D);
        check("t6_ovf_sticky", OVERFLOW, 1);

        // Frame after strobes that had no matching issue
        begin_frame();
        wait_done("t6", 100);
        pulse_reset();
        #1;
        check("t6_ovf_cleared", OVERFLOW, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
